sa_skew_feeder: RTL and testbench

SA_SKEW_FEEDER -- requirements
Module: sa_skew_feeder

---
 rtl/sa_pkg.sv | 13 +
 rtl/sa_sync_fifo.sv | 50 +++++
 rtl/sa_skew_feeder.sv | 103 ++++++++++
 tb/tb_sa_skew_feeder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared constants and state type for the systolic-array activation feeder.
package sa_pkg;

   localparam int SA_WIDTH = 16;
   localparam int SA_N     = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } feed_state_t;

endpackage

// File: rtl/sa_sync_fifo.sv
// Single-clock FIFO with combinational read port; DEPTH must be a power of two.
module sa_sync_fifo #(
   parameter int WIDTH_BITS = 8,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [WIDTH_BITS-1:0] wr_data,
   input  logic                  rd_en,
   output logic [WIDTH_BITS-1:0] rd_data,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH_BITS-1:0] mem [DEPTH];
   logic [AW-1:0]         wp, rp;
   logic [AW:0]           cnt;
   logic                  do_wr, do_rd;

   // A pop on an empty FIFO is dropped; a push on a full FIFO lands only if a pop frees the slot.
   assign do_rd   = rd_en & ~empty;
   assign do_wr   = wr_en & (~full | do_rd);
   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign rd_data = mem[rp];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wp] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_wr) wp <= wp + 1'b1;
         if (do_rd) rp <= rp + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/sa_skew_feeder.sv
// Buffers activation vectors and feeds them diagonally skewed into N array columns.
// Lane j trails lane 0 by j cycles; N must be at least 2.
module sa_skew_feeder
   import sa_pkg::*;
#(
   parameter int WIDTH = SA_WIDTH,
   parameter int N     = SA_N,
   parameter int DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*WIDTH-1:0] in_vec,
   input  logic               in_last,
   output logic [N*WIDTH-1:0] out_col,
   output logic [N-1:0]       out_vld,
   output logic               busy,
   output logic               done
);

   localparam int VW = N*WIDTH;
   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N-2);

   feed_state_t       state;
   logic [CW-1:0]     drain_cnt;
   logic              full, empty, push, pop, pop_last;
   logic [VW:0]       rd_data;
   logic [VW-1:0]     pop_vec;

   // rst gates in_ready so nothing is offered as accepted while held in reset.
   assign in_ready = rst & ~full & (state != ST_DRAIN);
   assign push     = in_valid & in_ready;
   assign pop      = (state == ST_STREAM) & ~empty;
   assign pop_vec  = rd_data[VW-1:0];
   assign pop_last = rd_data[VW];

   sa_sync_fifo #(.WIDTH_BITS(VW+1), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push),
      .wr_data ({in_last, in_vec}),
      .rd_en   (pop),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            // Vectors left over from the previous tile also restart streaming.
            ST_IDLE: if (push | ~empty) begin
               state <= ST_STREAM;
               busy  <= 1'b1;
            end
            ST_STREAM: if (pop & pop_last) begin
               state     <= ST_DRAIN;
               drain_cnt <= '0;
            end
            ST_DRAIN: if (drain_cnt == LAST_CNT) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end else begin
               drain_cnt <= drain_cnt + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   for (genvar j = 0; j < N; j++) begin : g_lane
      logic [WIDTH-1:0] dpipe [j+1];
      logic [j:0]       vld_pipe;

      // Data enters zeroed when no pop, so invalid slots never carry stale values.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            vld_pipe <= '0;
            for (int k = 0; k <= j; k++) dpipe[k] <= '0;
         end else begin
            vld_pipe[0] <= pop;
            dpipe[0]    <= pop ? pop_vec[j*WIDTH +: WIDTH] : '0;
            for (int k = 1; k <= j; k++) begin
               vld_pipe[k] <= vld_pipe[k-1];
               dpipe[k]    <= dpipe[k-1];
            end
         end
      end

      assign out_col[j*WIDTH +: WIDTH] = dpipe[j];
      assign out_vld[j]                = vld_pipe[j];
   end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Self-checking bench for sa_skew_feeder: directed table plus a queue-based reference model.
module tb_sa_skew_feeder;

   localparam int W  = 16;
   localparam int N  = 4;
   localparam int D  = 4;
   localparam int NW = N*W;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_last = 1'b0;
   logic [NW-1:0] in_vec = '0;
   logic          in_ready, busy, done;
   logic [NW-1:0] out_col;
   logic [N-1:0]  out_vld;

   int total = 0;
   int bad   = 0;

   sa_skew_feeder #(.WIDTH(W), .N(N), .DEPTH(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_vec   (in_vec),
      .in_last  (in_last),
      .out_col  (out_col),
      .out_vld  (out_vld),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Reference model: FIFO contents as a queue, tile phase as an int,
   // and a history of what lane 0 showed in recent cycles (lane j = j cycles ago).
   typedef struct { logic [NW-1:0] vec; logic last; } ent_t;
   typedef struct { logic [NW-1:0] vec; logic v; } l0_t;

   ent_t mq[$];
   l0_t  hist[$];
   int   mst;     // 0 idle, 1 stream, 2 drain
   int   dcnt;
   logic mdone;
   logic live;

   function automatic void model_reset();
      l0_t z;
      z.vec = '0;
      z.v   = 1'b0;
      mq.delete();
      hist.delete();
      for (int j = 0; j < N; j++) hist.push_back(z);
      mst   = 0;
      dcnt  = 0;
      mdone = 1'b0;
   endfunction

   function automatic logic exp_ready();
      return live && (mq.size() < D) && (mst != 2);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
      end
   endtask

   task automatic model_check();
      logic [NW-1:0] ec;
      logic [N-1:0]  ev;
      l0_t           h;
      ec = '0;
      ev = '0;
      for (int j = 0; j < N; j++) begin
         h     = hist[j];
         ev[j] = h.v;
         if (h.v) ec[j*W +: W] = h.vec[j*W +: W];
      end
      chk("out_col", 64'(out_col), 64'(ec));
      chk("out_vld", 64'(out_vld), 64'(ev));
      chk("busy", 64'(busy), 64'(mst != 0));
      chk("done", 64'(done), 64'(mdone));
      chk("in_ready", 64'(in_ready), 64'(exp_ready()));
   endtask

   task automatic model_step(input logic v, input logic [NW-1:0] vec, input logic last);
      logic acc, popped, nonempty;
      ent_t e;
      l0_t  h;
      acc      = v && exp_ready();
      nonempty = (mq.size() > 0);
      popped   = 1'b0;
      e.vec    = '0;
      e.last   = 1'b0;
      h.vec    = '0;
      h.v      = 1'b0;
      mdone    = 1'b0;
      if (mst == 1 && nonempty) begin
         e      = mq.pop_front();
         popped = 1'b1;
         h.vec  = e.vec;
         h.v    = 1'b1;
      end
      case (mst)
         0: if (acc || nonempty) mst = 1;
         1: if (popped && e.last) begin mst = 2; dcnt = 1; end
         2: if (dcnt == N-1) begin mst = 0; mdone = 1'b1; end else dcnt++;
         default: mst = 0;
      endcase
      if (acc) begin
         e.vec  = vec;
         e.last = last;
         mq.push_back(e);
      end
      hist.push_front(h);
      void'(hist.pop_back());
   endtask

   task automatic step(input logic v, input logic [NW-1:0] vec, input logic last);
      @(negedge clk);
      model_check();
      in_valid = v;
      in_vec   = v ? vec : '0;
      in_last  = v & last;
      model_step(v, vec, last);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
   endtask

   // Asserts reset mid-cycle; outputs must clear without waiting for a clock edge.
   task automatic apply_reset();
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_vec   = '0;
      live     = 1'b0;
      model_reset();
      #1 model_check();
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_check();
      rst  = 1'b1;
      live = 1'b1;
      model_step(1'b0, '0, 1'b0);
   endtask

   typedef struct {
      logic          v;
      logic [NW-1:0] vec;
      logic          last;
      logic [N-1:0]  ev;
      logic [NW-1:0] ec;
      logic          eb;
      logic          ed;
   } row_t;

   row_t tbl [7];

   task automatic run_table();
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk($sformatf("tbl%0d_vld", i), 64'(out_vld), 64'(tbl[i].ev));
         chk($sformatf("tbl%0d_col", i), 64'(out_col), 64'(tbl[i].ec));
         chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].eb));
         chk($sformatf("tbl%0d_done", i), 64'(done), 64'(tbl[i].ed));
         model_check();
         in_valid = tbl[i].v;
         in_vec   = tbl[i].vec;
         in_last  = tbl[i].last;
         model_step(tbl[i].v, tbl[i].vec, tbl[i].last);
      end
   endtask

   function automatic logic [NW-1:0] rand_vec();
      logic [NW-1:0] r;
      r = {$urandom, $urandom};
      for (int j = 0; j < N; j++) begin
         case ($urandom_range(0, 7))
            0: r[j*W +: W] = 16'h8000;
            1: r[j*W +: W] = 16'h7fff;
            default: ;
         endcase
      end
      return r;
   endfunction

   initial begin
      // Single vector {1,2,3,4} accepted in row 0, lanes fire at rows 2..5.
      tbl[0] = '{1'b1, 64'h0004_0003_0002_0001, 1'b1, 4'b0000, 64'h0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 64'h0, 1'b0, 4'b0000, 64'h0, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 64'h0, 1'b0, 4'b0001, 64'h0000_0000_0000_0001, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 64'h0, 1'b0, 4'b0010, 64'h0000_0000_0002_0000, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 64'h0, 1'b0, 4'b0100, 64'h0000_0003_0000_0000, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 64'h0, 1'b0, 4'b1000, 64'h0004_0000_0000_0000, 1'b0, 1'b1};
      tbl[6] = '{1'b0, 64'h0, 1'b0, 4'b0000, 64'h0, 1'b0, 1'b0};

      live = 1'b0;
      model_reset();
      apply_reset();
      run_table();
      idle(2);

      // Back-to-back tile of six vectors.
      for (int i = 0; i < 6; i++) step(1'b1, rand_vec(), i == 5);
      idle(8);

      // Two-cycle gap between the first and second vector.
      step(1'b1, 64'h0014_0013_0012_0011, 1'b0);
      idle(2);
      step(1'b1, 64'h0024_0023_0022_0021, 1'b1);
      idle(8);

      // Signed extremes on every lane.
      step(1'b1, 64'h8000_7fff_7fff_8000, 1'b0);
      step(1'b1, 64'h7fff_8000_ffff_0001, 1'b1);
      idle(8);

      // Reset part-way through a six-vector tile, then a fresh single-vector tile.
      for (int i = 0; i < 3; i++) step(1'b1, rand_vec(), 1'b0);
      apply_reset();
      idle(8);
      run_table();
      idle(2);

      // Random traffic with random gaps and tile lengths.
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 9) < 6, rand_vec(), $urandom_range(0, 4) == 0);
      step(1'b1, rand_vec(), 1'b1);
      idle(12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
